// File: rtl/relay_seq_pkg.sv
// Shared state codes, relay patterns and constants for relay_sequencer.
package relay_seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRECHG = 3'd1;
  localparam logic [2:0] S_OVL    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_TRIP   = 3'd5;

  localparam logic [3:0] RLY_IDLE = 4'b0000;
  localparam logic [3:0] RLY_PRE  = 4'b0001;
  localparam logic [3:0] RLY_OVL  = 4'b0011;
  localparam logic [3:0] RLY_RUN  = 4'b0110;
  localparam logic [3:0] RLY_STOP = 4'b0110;
  localparam logic [3:0] RLY_TRIP = 4'b0000;

  localparam int FB_TIMEOUT = 20;

  function automatic logic [3:0] relay_pat(input logic [2:0] s);
    logic [3:0] r;
    r = RLY_IDLE;
    case (s)
      S_PRECHG: r = RLY_PRE;
      S_OVL:    r = RLY_OVL;
      S_RUN:    r = RLY_RUN;
      S_STOP:   r = RLY_STOP;
      S_TRIP:   r = RLY_TRIP;
      default:  r = RLY_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/relay_sequencer_tick_timer.sv
// Prescaled dwell timer: restart loads max(load,1) ticks and clears counts.
// expired pulses on the last cycle of the dwell.
module tick_timer #(
  parameter int TICK_DIV = 200000,
  parameter int TW       = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          restart,
  input  logic [TW-1:0] load,
  output logic          expired
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic [TW-1:0] cnt;
  logic [TW-1:0] lim;
  logic          last;

  assign last    = (presc == PW'(TICK_DIV - 1));
  assign expired = last && (cnt == lim - TW'(1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc <= '0;
      cnt   <= '0;
      lim   <= '0;
    end else if (restart) begin
      presc <= '0;
      cnt   <= '0;
      lim   <= (load == '0) ? TW'(1) : load;
    end else begin
      presc <= last ? '0 : presc + PW'(1);
      // saturate rather than wrap
      if (last && (cnt != '1))
        cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/relay_sequencer.sv
// Contactor sequencer FSM with registered relay/PWM outputs and trip latch.
// Optional relay feedback supervision: RELAY_SEQ_FEEDBACK_EN.
module relay_sequencer
  import relay_seq_pkg::*;
#(
  parameter int TICK_DIV = 200000,
  parameter int TW       = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          cmd_start,
  input  logic          cmd_stop,
  input  logic          fault_n,
  input  logic          trip_clear,
  input  logic [TW-1:0] t_pre,
  input  logic [TW-1:0] t_ovl,
  input  logic [TW-1:0] t_off,
  input  logic [3:0]    relay_fb,
  output logic [3:0]    relay,
  output logic          pwm_en,
  output logic [2:0]    state,
  output logic          tripped,
  output logic          fb_err
);

  logic [2:0]    nxt;
  logic [3:0]    relay_d;
  logic          pwm_d;
  logic          trip_d;
  logic          fbe_d;
  logic          restart;
  logic [TW-1:0] load;
  logic          expired;
  logic          fb_fault;

  assign restart = (nxt != state);

  always_comb begin
    load = '0;
    case (nxt)
      S_PRECHG: load = t_pre;
      S_OVL:    load = t_ovl;
      S_STOP:   load = t_off;
      default:  load = '0;
    endcase
  end

  tick_timer #(.TICK_DIV(TICK_DIV), .TW(TW)) u_dwell (
    .CLK     (CLK),
    .RESET   (RESET),
    .restart (restart),
    .load    (load),
    .expired (expired)
  );

`ifdef RELAY_SEQ_FEEDBACK_EN
  logic fb_chg;
  logic fb_exp;
  logic fb_to;
  logic unused_fb;

  assign fb_chg    = (relay_d[2:0] != relay[2:0]);
  assign unused_fb = relay_fb[3];

  tick_timer #(.TICK_DIV(TICK_DIV), .TW(TW)) u_fb (
    .CLK     (CLK),
    .RESET   (RESET),
    .restart (fb_chg),
    .load    (TW'(FB_TIMEOUT)),
    .expired (fb_exp)
  );

  always_ff @(posedge CLK) begin
    if (RESET)       fb_to <= 1'b0;
    else if (fb_chg) fb_to <= 1'b0;
    else if (fb_exp) fb_to <= 1'b1;
  end

  assign fb_fault = (fb_to || fb_exp) && (relay_fb[2:0] != relay[2:0]);
`else
  logic unused_fb;
  assign unused_fb = ^relay_fb;
  assign fb_fault  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      relay   <= RLY_IDLE;
      pwm_en  <= 1'b0;
      tripped <= 1'b0;
      fb_err  <= 1'b0;
    end else begin
      state   <= nxt;
      relay   <= relay_d;
      pwm_en  <= pwm_d;
      tripped <= trip_d;
      fb_err  <= fbe_d;
    end
  end

  // fault > stop > expiry > start
  always_comb begin
    nxt = state;
    if (!fault_n || fb_fault) begin
      nxt = S_TRIP;
    end else begin
      case (state)
        S_IDLE:   if (cmd_start && !tripped) nxt = S_PRECHG;
        S_PRECHG: if (cmd_stop) nxt = S_IDLE;
                  else if (expired) nxt = S_OVL;
        S_OVL:    if (cmd_stop) nxt = S_IDLE;
                  else if (expired) nxt = S_RUN;
        S_RUN:    if (cmd_stop) nxt = S_STOP;
        S_STOP:   if (expired) nxt = S_IDLE;
        S_TRIP:   if (trip_clear) nxt = S_IDLE;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    relay_d = relay_pat(nxt);
    pwm_d   = (nxt == S_RUN);
    trip_d  = (nxt == S_TRIP);
    fbe_d   = (nxt == S_TRIP) &&
              (fb_err || (fb_fault && state != S_TRIP));
  end

endmodule

// File: tb/tb_relay_sequencer.sv
// Directed table-driven bench for relay_sequencer (TICK_DIV=10).
// Default build: feedback supervision disabled.
module tb_relay_sequencer;

  localparam int TD = 10;
  localparam int TW = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          cmd_start;
  logic          cmd_stop;
  logic          fault_n;
  logic          trip_clear;
  logic [TW-1:0] t_pre;
  logic [TW-1:0] t_ovl;
  logic [TW-1:0] t_off;
  logic [3:0]    relay_fb;
  logic [3:0]    relay;
  logic          pwm_en;
  logic [2:0]    state;
  logic          tripped;
  logic          fb_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  relay_sequencer #(.TICK_DIV(TD), .TW(TW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .fault_n    (fault_n),
    .trip_clear (trip_clear),
    .t_pre      (t_pre),
    .t_ovl      (t_ovl),
    .t_off      (t_off),
    .relay_fb   (relay_fb),
    .relay      (relay),
    .pwm_en     (pwm_en),
    .state      (state),
    .tripped    (tripped),
    .fb_err     (fb_err)
  );

  typedef struct {
    string       name;
    logic        st;
    logic        sp;
    logic        fn;
    logic        tc;
    int unsigned w;
    logic [2:0]  es;
    logic [3:0]  er;
    logic        ep;
    logic        et;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string name, logic st, logic sp,
                              logic fn, logic tc, int unsigned w,
                              logic [2:0] es, logic [3:0] er,
                              logic ep, logic et);
    vec_t v;
    v.name = name; v.st = st; v.sp = sp; v.fn = fn; v.tc = tc;
    v.w = w; v.es = es; v.er = er; v.ep = ep; v.et = et;
    return v;
  endfunction

  task automatic check(string nm, logic [2:0] es, logic [3:0] er,
                       logic ep, logic et);
    n_chk++;
    if ({state, relay, pwm_en, tripped, fb_err} !== {es, er, ep, et, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: got st=%0d rly=%b pwm=%b trp=%b fbe=%b, want st=%0d rly=%b pwm=%b trp=%b fbe=0",
               nm, state, relay, pwm_en, tripped, fb_err, es, er, ep, et);
    end
  endtask

  // Called at a negedge: inputs sampled at next posedge, pulses dropped
  // after it, then w further edges before checking.
  task automatic step(input vec_t v);
    cmd_start  = v.st;
    cmd_stop   = v.sp;
    fault_n    = v.fn;
    trip_clear = v.tc;
    @(posedge CLK);
    #1;
    cmd_start  = 1'b0;
    cmd_stop   = 1'b0;
    trip_clear = 1'b0;
    repeat (v.w) @(posedge CLK);
    @(negedge CLK);
    check(v.name, v.es, v.er, v.ep, v.et);
  endtask

  initial begin
    RESET = 1'b1;
    cmd_start = 1'b0; cmd_stop = 1'b0;
    fault_n = 1'b1; trip_clear = 1'b0;
    t_pre = 16'd3; t_ovl = 16'd2; t_off = 16'd4;
    relay_fb = 4'b0000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset", 3'd0, 4'b0000, 1'b0, 1'b0);
    RESET = 1'b0;

    // normal run: PRECHG 30, OVERLAP 20, STOPPING 40 cycles
    tv.push_back(mk("n_start",   1,0,1,0, 0, 3'd1,4'b0001,0,0));
    tv.push_back(mk("n_pre_end", 0,0,1,0,28, 3'd1,4'b0001,0,0));
    tv.push_back(mk("n_ovl",     0,0,1,0, 0, 3'd2,4'b0011,0,0));
    tv.push_back(mk("n_ovl_end", 0,0,1,0,18, 3'd2,4'b0011,0,0));
    tv.push_back(mk("n_run",     0,0,1,0, 0, 3'd3,4'b0110,1,0));
    tv.push_back(mk("n_run_hold",0,0,1,0, 5, 3'd3,4'b0110,1,0));
    tv.push_back(mk("n_stop",    0,1,1,0, 0, 3'd4,4'b0110,0,0));
    tv.push_back(mk("n_stop_end",0,0,1,0,38, 3'd4,4'b0110,0,0));
    tv.push_back(mk("n_idle",    0,0,1,0, 0, 3'd0,4'b0000,0,0));
    tv.push_back(mk("idle_stop", 0,1,1,0, 0, 3'd0,4'b0000,0,0));
    // fault in RUN
    tv.push_back(mk("f_start",   1,0,1,0, 0, 3'd1,4'b0001,0,0));
    tv.push_back(mk("f_ovl",     0,0,1,0,29, 3'd2,4'b0011,0,0));
    tv.push_back(mk("f_run",     0,0,1,0,19, 3'd3,4'b0110,1,0));
    tv.push_back(mk("f_trip",    0,0,0,0, 0, 3'd5,4'b0000,0,1));
    tv.push_back(mk("f_clr_flt", 0,0,0,1, 0, 3'd5,4'b0000,0,1));
    tv.push_back(mk("f_hold",    0,0,1,0, 0, 3'd5,4'b0000,0,1));
    tv.push_back(mk("f_clr_ok",  0,0,1,1, 0, 3'd0,4'b0000,0,0));
    // abort in PRECHG
    tv.push_back(mk("a_start",   1,0,1,0, 0, 3'd1,4'b0001,0,0));
    tv.push_back(mk("a_pre",     0,0,1,0, 5, 3'd1,4'b0001,0,0));
    tv.push_back(mk("a_abort",   0,1,1,0, 0, 3'd0,4'b0000,0,0));
    // start ignored in TRIP
    tv.push_back(mk("t_trip",    0,0,0,0, 0, 3'd5,4'b0000,0,1));
    tv.push_back(mk("t_start",   1,0,1,0, 0, 3'd5,4'b0000,0,1));
    tv.push_back(mk("t_stop",    0,1,1,0, 0, 3'd5,4'b0000,0,1));
    tv.push_back(mk("t_clr",     0,0,1,1, 0, 3'd0,4'b0000,0,0));
    // fault beats start
    tv.push_back(mk("s_flt_st",  1,0,0,0, 0, 3'd5,4'b0000,0,1));
    tv.push_back(mk("s_clr",     0,0,1,1, 0, 3'd0,4'b0000,0,0));
    // stop beats OVERLAP expiry
    tv.push_back(mk("o_start",   1,0,1,0, 0, 3'd1,4'b0001,0,0));
    tv.push_back(mk("o_ovl",     0,0,1,0,29, 3'd2,4'b0011,0,0));
    tv.push_back(mk("o_ovl_end", 0,0,1,0,18, 3'd2,4'b0011,0,0));
    tv.push_back(mk("o_stop_exp",0,1,1,0, 0, 3'd0,4'b0000,0,0));

    foreach (tv[i]) step(tv[i]);

    // zero dwell, and a later t_pre change must not stretch PRECHG
    t_pre = 16'd0;
    step(mk("z_start",   1,0,1,0, 0, 3'd1,4'b0001,0,0));
    t_pre = 16'd5;
    step(mk("z_pre_end", 0,0,1,0, 8, 3'd1,4'b0001,0,0));
    step(mk("z_ovl",     0,0,1,0, 0, 3'd2,4'b0011,0,0));
    step(mk("z_abort",   0,1,1,0, 0, 3'd0,4'b0000,0,0));
    t_pre = 16'd3;

    // RESET in RUN
    step(mk("r_start",   1,0,1,0, 0, 3'd1,4'b0001,0,0));
    step(mk("r_ovl",     0,0,1,0,29, 3'd2,4'b0011,0,0));
    step(mk("r_run",     0,0,1,0,19, 3'd3,4'b0110,1,0));
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("r_reset_run", 3'd0, 4'b0000, 1'b0, 1'b0);
    RESET = 1'b0;

    // RESET clears the trip latch
    step(mk("r_trip",    0,0,0,0, 0, 3'd5,4'b0000,0,1));
    fault_n = 1'b1;
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("r_reset_trip", 3'd0, 4'b0000, 1'b0, 1'b0);
    RESET = 1'b0;
    step(mk("r_after",   1,0,1,0, 0, 3'd1,4'b0001,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/relay_sequencer.md
# relay_sequencer

Power-stage contactor sequencer on the DSP bus side of the FPGA. It drives the four relay outputs through a timed precharge → main-close → run → open sequence and gates the PWM path to the power stage. It trips all outputs on a fault and reports its state for the bus status register. Commands and dwell times come from bus-written registers in the top level.

## Interface
Parameters:
- TICK_DIV, 200000: CLK cycles per timer tick (1 ms at 200 MHz).
- TW, 16: width of dwell-time inputs, in ticks.

Ports:
- CLK  in  1  system clock (200 MHz domain).
- RESET  in  1  synchronous, active-high reset.
- cmd_start  in  1  single-cycle start request.
- cmd_stop  in  1  single-cycle stop request.
- fault_n  in  1  active-low fault, already synchronised (FAULT_XINT).
- trip_clear  in  1  single-cycle latched-trip clear.
- t_pre  in  TW  precharge dwell, ticks.
- t_ovl  in  TW  precharge/main overlap dwell, ticks.
- t_off  in  TW  PWM-off-to-relay-open dwell, ticks.
- relay_fb  in  4  auxiliary contact feedback, active-high (used only with the macro).
- relay  out  4  relay drives: [0] precharge, [1] main, [2] fan, [3] spare (always 0).
- pwm_en  out  1  PWM gate enable to the power stage.
- state  out  3  current state code.
- tripped  out  1  latched trip flag.
- fb_err  out  1  feedback mismatch caused the trip.

## Operation
- States and codes: IDLE=0, PRECHG=1, OVERLAP=2, RUN=3, STOPPING=4, TRIP=5.
- Output mapping, all registered:
  - IDLE: relay=0000, pwm_en=0.
  - PRECHG: relay=0001.
  - OVERLAP: relay=0011.
  - RUN: relay=0110, pwm_en=1.
  - STOPPING: relay=0110, pwm_en=0.
  - TRIP: relay=0000, pwm_en=0.
- Transitions:
  - IDLE→PRECHG on cmd_start when tripped=0.
  - PRECHG→OVERLAP after t_pre ticks.
  - OVERLAP→RUN after t_ovl ticks.
  - RUN→STOPPING on cmd_stop.
  - STOPPING→IDLE after t_off ticks.
  - PRECHG or OVERLAP→IDLE on cmd_stop (abort; relays open immediately).
  - Any state→TRIP when fault_n=0. Sets tripped=1.
  - TRIP→IDLE on trip_clear only if fault_n=1. trip_clear is ignored otherwise and in all other states.
- Priority, same cycle: fault > cmd_stop > timer expiry > cmd_start.
- cmd_start outside IDLE is ignored. cmd_stop in IDLE or TRIP is ignored.
- Dwell: a value N gives N ticks. N=0 is treated as 1.
  - Tick prescaler and tick counter both clear on every state entry, so dwell is exactly max(N,1)·TICK_DIV cycles.
- Dwell inputs are sampled on entry to the state. Later changes do not affect the running dwell.

## Timing
- Reset values: state=IDLE, relay=0000, pwm_en=0, tripped=0, fb_err=0, counters=0.
- Command latency: an input in cycle k gives new state and outputs at edge k+1.
- Fault latency: fault_n low sampled at edge k gives relay=0000 and pwm_en=0 at edge k+1.
- RESET mid-sequence: all outputs return to reset values at the next edge. The trip latch also clears.
- Prescaler: counts 0..TICK_DIV-1 and wraps. The tick counter saturates at 2^TW-1; it never wraps.

## Configuration
- RELAY_SEQ_FEEDBACK_EN defined:
  - After any change of relay[2:0], relay_fb[2:0] must equal relay[2:0] within 20 ticks.
  - While the mismatch persists past 20 ticks, the block goes to TRIP with fb_err=1.
  - fb_err clears with tripped.
- Macro undefined: relay_fb is ignored and fb_err is tied to 0.

## Structure
- Package relay_seq_pkg:
  - state code localparams.
  - per-state relay pattern constants.
  - feedback timeout constant (20).
- Sub-module tick_timer:
  - prescaler and TW-bit tick counter.
  - inputs: restart, load value.
  - output: single-cycle expired pulse.
- Top-level FSM and output registers live in relay_sequencer.

## Test plan
Bench parameters: TICK_DIV=10, t_pre=3, t_ovl=2, t_off=4.
- Normal run: cmd_start at cycle 5.
  - relay=0001 at edge 6.
  - relay=0011 at edge 36.
  - relay=0110, pwm_en=1 at edge 56.
  - Then cmd_stop: pwm_en=0 next edge, relay=0000 40 cycles later.
- Fault in RUN: fault_n=0 for one cycle gives relay=0000, pwm_en=0, state=5 next edge.
  - trip_clear while fault_n=0 leaves state=5.
  - trip_clear after fault_n=1 gives state=0.
- Abort: cmd_stop during PRECHG gives relay=0000, state=0 next edge. A cmd_start in TRIP is ignored.
- Simultaneous events: fault_n=0 and cmd_start together in IDLE gives TRIP. cmd_stop coinciding with OVERLAP expiry gives IDLE, not RUN.
- Zero dwell and reset: t_pre=0 gives PRECHG lasting 10 cycles. RESET asserted in RUN gives all outputs at reset values next edge.
- With RELAY_SEQ_FEEDBACK_EN: relay_fb held 000 after start gives TRIP with fb_err=1 after 20 ticks (200 cycles).
